// File: rtl/root_pkg.sv
// ---------------------------------------------------------------------------
// root_pkg
// Shared definitions for the iterative integer root unit (int_root) and its
// helpers: root mode encodings, the controller state encoding, and constant
// functions that derive the starting bit position and iteration count from
// the operand width.
// ---------------------------------------------------------------------------
package root_pkg;

  // Root selection, sampled together with start
  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  // Controller states of the digit-by-digit root iteration
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MUL_WAIT,
    TRIAL,
    NEXT
  } state_t;

  // Bits of the operand consumed per result bit: 2 for sqrt, 3 for cbrt
  function automatic int rootStep(input logic rootMode);
    return (rootMode == MODE_CBRT) ? 3 : 2;
  endfunction

  // Bit position of the most significant operand group: the largest multiple
  // of the step that still lies inside the operand
  function automatic int initialShift(input int width, input logic rootMode);
    int step;
    step = rootStep(rootMode);
    return step * ((width - 1) / step);
  endfunction

  // Number of result bits produced, one per iteration
  function automatic int iterCount(input int width, input logic rootMode);
    return initialShift(width, rootMode) / rootStep(rootMode) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// ---------------------------------------------------------------------------
// shift_add_mult
// Radix-2 shift-add multiplier. One multiplier bit is consumed per cycle,
// the first one on the accepting edge, so done_o pulses W cycles after the
// start cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, returns the unit to idle
//   start_i    load operands and begin; ignored while busy_o is high
//   a_i, b_i   W-bit unsigned operands
//   busy_o     high while partial products are still being accumulated
//   done_o     one-cycle pulse when product_o is final
//   product_o  2W-bit product, held until the next start
// ---------------------------------------------------------------------------
module shift_add_mult #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] a_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;

  // The accepting edge already folds in multiplier bit 0; each busy edge
  // then adds the next shifted multiplicand when its multiplier bit is set.
  // cnt_q holds the number of bits still to be consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        acc_q <= b_i[0] ? {{W{1'b0}}, a_i} : '0;
        a_q   <= {{W{1'b0}}, a_i} << 1;
        b_q   <= b_i >> 1;
        cnt_q <= CW'(W - 1);
        if (W == 1) begin
          done_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (busy_q) begin
        if (b_q[0]) begin
          acc_q <= acc_q + a_q;
        end
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign product_o = acc_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: rtl/int_root.sv
// ---------------------------------------------------------------------------
// int_root
// Iterative floor square root / floor cube root of a WIDTH-bit unsigned
// operand, selected per request, with the remainder. Works digit by digit
// from the most significant operand group down: each iteration doubles the
// partial root and keeps the extra 1 bit if the remainder can absorb the
// growth of the power. Cube mode needs y*(y+1) per iteration and gets it
// from a single shared shift-add multiplier.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; aborts any operation
//   start    request strobe, sampled in IDLE only
//   mode     0 = square root, 1 = cube root (sampled with start)
//   x_in     WIDTH-bit operand (sampled with start)
//   y_out    floor root, held until the next completion
//   rem_out  x_in - y_out^2 or x_in - y_out^3
//   busy_o   high from the cycle after acceptance until completion
//   done_o   one-cycle pulse when y_out/rem_out update
// ---------------------------------------------------------------------------
module int_root
  import root_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RW    = (WIDTH + 1) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  output logic [RW-1:0]    y_out,
  output logic [WIDTH-1:0] rem_out,
  output logic             busy_o,
  output logic             done_o
);

  // Trial term / product width; wide enough for 3*y*(y+1)+1
  localparam int PW = 2 * RW + 2;
  // Shift amounts never exceed WIDTH-1
  localparam int SW = $clog2(WIDTH);

  localparam logic [SW-1:0] S0_SQRT   = SW'(initialShift(WIDTH, MODE_SQRT));
  localparam logic [SW-1:0] S0_CBRT   = SW'(initialShift(WIDTH, MODE_CBRT));
  localparam logic [SW-1:0] STEP_SQRT = SW'(rootStep(MODE_SQRT));
  localparam logic [SW-1:0] STEP_CBRT = SW'(rootStep(MODE_CBRT));

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    y_q, y_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [SW-1:0]    s_q, s_d;
  logic [PW-1:0]    p_q, p_d;
  logic [RW-1:0]    yOut_q, yOut_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [RW-1:0]    yShift;
  logic [SW-1:0]    step;
  logic [PW-1:0]    trial;
  logic [PW-1:0]    remHi;
  logic [WIDTH-1:0] trialShifted;

  logic             multStart;
  logic             multBusy;
  logic             multDone;
  logic [2*RW-1:0]  multProduct;

  // Datapath helpers. The trial is compared against the remainder shifted
  // down to the current group, so nothing shifted up ever leaves WIDTH
  // bits. When the compare passes, trial <= rem>>s, which guarantees that
  // the low WIDTH bits of the trial, shifted back up, are the exact
  // subtrahend and the subtraction cannot underflow.
  always_comb begin
    yShift       = y_q << 1;
    step         = (mode_q == MODE_CBRT) ? STEP_CBRT : STEP_SQRT;
    remHi        = PW'(rem_q >> s_q);
    trial        = (mode_q == MODE_CBRT) ? ((p_q << 1) + p_q + PW'(1))
                                         : PW'({y_q, 1'b1});
    trialShifted = trial[WIDTH-1:0] << s_q;
  end

  // Only one multiplier is needed; its operands are the freshly doubled
  // root and that value plus one (the doubled root is even, so OR-ing in
  // bit 0 is the increment and cannot overflow RW bits).
  shift_add_mult #(
    .W(RW)
  ) uMult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (multStart),
    .a_i       (yShift),
    .b_i       (yShift | RW'(1)),
    .busy_o    (multBusy),
    .done_o    (multDone),
    .product_o (multProduct)
  );

  // Next-state and datapath update for the iteration controller.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    y_d       = y_q;
    rem_d     = rem_q;
    s_d       = s_q;
    p_d       = p_q;
    yOut_d    = yOut_q;
    remOut_d  = remOut_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    multStart = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = x_in;
          mode_d  = mode;
          y_d     = '0;
          s_d     = (mode == MODE_CBRT) ? S0_CBRT : S0_SQRT;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        y_d = yShift;
        if (mode_q == MODE_CBRT) begin
          multStart = 1'b1;
          state_d   = MUL_WAIT;
        end else begin
          state_d = TRIAL;
        end
      end

      MUL_WAIT: begin
        // The product is final on the done pulse, once busy has dropped
        if (multDone && !multBusy) begin
          p_d     = {2'b00, multProduct};
          state_d = TRIAL;
        end
      end

      TRIAL: begin
        if (remHi >= trial) begin
          rem_d = rem_q - trialShifted;
          y_d   = y_q + RW'(1);
        end
        state_d = NEXT;
      end

      NEXT: begin
        if (s_q >= step) begin
          s_d     = s_q - step;
          state_d = SHIFT;
        end else begin
          yOut_d   = y_q;
          remOut_d = rem_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset clears outputs and aborts any
  // operation in progress without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SQRT;
      y_q      <= '0;
      rem_q    <= '0;
      s_q      <= '0;
      p_q      <= '0;
      yOut_q   <= '0;
      remOut_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      y_q      <= y_d;
      rem_q    <= rem_d;
      s_q      <= s_d;
      p_q      <= p_d;
      yOut_q   <= yOut_d;
      remOut_q <= remOut_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y_out   = yOut_q;
  assign rem_out = remOut_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_int_root.sv
// ---------------------------------------------------------------------------
// tb_int_root
// Bench for int_root. An 8-bit instance is compared every cycle against a
// behavioural model (root found by plain search, completion scheduled from
// the iteration count and per-iteration cost). A 16-bit instance gets a
// couple of directed wide-operand requests.
// ---------------------------------------------------------------------------
module tb_int_root;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] x_in;
  logic [3:0] y_out;
  logic [7:0] rem_out;
  logic       busy_o;
  logic       done_o;

  logic        start16;
  logic        mode16;
  logic [15:0] x16;
  logic [7:0]  y16;
  logic [15:0] rem16;
  logic        busy16;
  logic        done16;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   acceptCyc   = 0;
  logic checkEn     = 1'b0;

  // Behavioural model state
  logic   mActive  = 1'b0;
  logic   mDone    = 1'b0;
  int     mCount   = 0;
  longint mPendY   = 0;
  longint mPendRem = 0;
  longint mYOut    = 0;
  longint mRemOut  = 0;

  always #5 clk = ~clk;

  int_root #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .x_in    (x_in),
    .y_out   (y_out),
    .rem_out (rem_out),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  int_root #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .start   (start16),
    .mode    (mode16),
    .x_in    (x16),
    .y_out   (y16),
    .rem_out (rem16),
    .busy_o  (busy16),
    .done_o  (done16)
  );

  // b^2 or b^3
  function automatic longint ipow(input longint b, input logic m);
    return m ? b * b * b : b * b;
  endfunction

  // Largest y with y^k <= x, by straightforward search
  function automatic longint rootOf(input logic m, input longint x);
    longint y;
    y = 0;
    while (ipow(y + 1, m) <= x) y++;
    return y;
  endfunction

  // Edges from acceptance to done: iterations times cycles per iteration
  function automatic int latencyOf(input int width, input logic m);
    int rw, st, s0, n, l;
    rw = (width + 1) / 2;
    st = m ? 3 : 2;
    s0 = st * ((width - 1) / st);
    n  = s0 / st + 1;
    l  = m ? 3 + rw : 3;
    return n * l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: accept in idle, ignore start while busy, finish after the
  // computed number of edges, hold results until the next completion.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
      mCount  <= 0;
      mYOut   <= 0;
      mRemOut <= 0;
    end else begin
      mDone <= 1'b0;
      if (!mActive) begin
        if (start) begin
          mActive  <= 1'b1;
          mCount   <= latencyOf(8, mode);
          mPendY   <= rootOf(mode, longint'(x_in));
          mPendRem <= longint'(x_in) - ipow(rootOf(mode, longint'(x_in)), mode);
        end
      end else if (mCount == 1) begin
        mActive <= 1'b0;
        mDone   <= 1'b1;
        mYOut   <= mPendY;
        mRemOut <= mPendRem;
      end else begin
        mCount <= mCount - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle compare of the 8-bit instance against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy_o", longint'(busy_o), longint'(mActive));
      checkOutput("done_o", longint'(done_o), longint'(mDone));
      checkOutput("y_out", longint'(y_out), mYOut);
      checkOutput("rem_out", longint'(rem_out), mRemOut);
    end
  end

  // Raise start now (caller is away from the rising edge), hold it for the
  // accepting edge, then scramble the inputs so later use of them shows up
  task automatic applyStimulus(input logic m, input logic [7:0] x);
    start = 1'b1;
    mode  = m;
    x_in  = x;
    @(posedge clk);
    #1 acceptCyc = cyc;
    #1 start = 1'b0;
    mode = 1'($urandom_range(0, 1));
    x_in = 8'($urandom);
  endtask

  task automatic waitDone(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        lat  = cyc - acceptCyc + 1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done timeout: got no done_o expected a pulse within 400 cycles");
    end
  endtask

  task automatic expectResult(input string name, input int expY, input int expRem, input int expLat);
    int lat;
    bit seen;
    waitDone(lat, seen);
    if (seen) begin
      checkOutput({name, " y"}, longint'(y_out), expY);
      checkOutput({name, " rem"}, longint'(rem_out), expRem);
      checkOutput({name, " latency"}, lat, expLat);
    end
  endtask

  // Floor-root property on the DUT's own result for operand x
  task automatic checkBound(input logic m, input logic [7:0] x);
    longint y;
    logic ok;
    y  = longint'(y_out);
    ok = (ipow(y, m) <= longint'(x)) && (ipow(y + 1, m) > longint'(x));
    checkOutput("root bound", longint'(ok), 1);
  endtask

  task automatic run16(input logic m, input logic [15:0] x, input int expY,
                       input int expRem, input int expLat);
    int acc16;
    int lat;
    bit seen;
    start16 = 1'b1;
    mode16  = m;
    x16     = x;
    @(posedge clk);
    #1 acc16 = cyc;
    checkOutput("busy16 after accept", longint'(busy16), 1);
    #1 start16 = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done16) begin
        seen = 1'b1;
        lat  = cyc - acc16 + 1;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done16 timeout: got no done_o expected a pulse within 200 cycles");
    end else begin
      checkOutput("w16 y", longint'(y16), expY);
      checkOutput("w16 rem", longint'(rem16), expRem);
      checkOutput("w16 latency", lat, expLat);
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  extraDone;
    logic       rm;
    logic [7:0] rx;

    rst = 1'b0; start = 1'b0; mode = 1'b0; x_in = '0;
    start16 = 1'b0; mode16 = 1'b0; x16 = '0;

    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", longint'(busy_o), 0);
    checkOutput("reset done", longint'(done_o), 0);
    checkOutput("reset y", longint'(y_out), 0);
    checkOutput("reset rem", longint'(rem_out), 0);
    #2 rst = 1'b0;
    checkEn = 1'b1;

    // Hand-computed results and latencies
    applyStimulus(1'b1, 8'd216); expectResult("cbrt 216", 6, 0, 22);
    applyStimulus(1'b1, 8'd255); expectResult("cbrt 255", 6, 39, 22);
    applyStimulus(1'b0, 8'd255); expectResult("sqrt 255", 15, 30, 13);
    applyStimulus(1'b0, 8'd0);   expectResult("sqrt 0", 0, 0, 13);
    applyStimulus(1'b1, 8'd0);   expectResult("cbrt 0", 0, 0, 22);

    // A second start mid-operation is ignored
    applyStimulus(1'b1, 8'd200);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 1'b0; x_in = 8'd99;
    @(negedge clk);
    start = 1'b0;
    expectResult("ignored start", 5, 75, 22);
    extraDone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) extraDone++;
    end
    checkOutput("single done", extraDone, 0);

    // Reset while the multiplier is running
    applyStimulus(1'b1, 8'd100);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort busy", longint'(busy_o), 0);
    checkOutput("abort done", longint'(done_o), 0);
    checkOutput("abort y", longint'(y_out), 0);
    checkOutput("abort rem", longint'(rem_out), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(1'b1, 8'd100); expectResult("after abort", 4, 36, 22);

    // Wide operands
    run16(1'b1, 16'd65535, 40, 1535, 67);
    run16(1'b0, 16'd65535, 255, 510, 25);

    // Full sweep in both modes, back to back
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        applyStimulus(1'(m), 8'(x));
        waitDone(lat, seen);
        if (seen) checkBound(1'(m), 8'(x));
      end
    end

    // Random requests, gaps and stray starts while busy
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rm = 1'($urandom_range(0, 1));
      rx = 8'($urandom);
      applyStimulus(rm, rx);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        start = 1'b1;
        mode  = 1'($urandom_range(0, 1));
        x_in  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      waitDone(lat, seen);
      if (seen) checkBound(rm, rx);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_root.md
# int_root

Parametrised iterative integer root unit: computes floor square root or floor cube root of a WIDTH-bit unsigned operand, selected per request, plus the remainder. It generalises the team's fixed 8-bit cube-root block in three ways: operand width, a runtime root mode, and a shift-add multiplier in place of repeated addition. It sits beside the function datapaths (e.g. `y = a^2 + b^(1/3)`) and shares their start/busy handshake.

## Interface
- WIDTH, 8: operand width in bits, 4..32.
- RW, (WIDTH+1)/2: result and multiplier operand width (derived, not overridden).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled in IDLE only.
- mode  in  1  0 = square root, 1 = cube root; sampled with start.
- x_in  in  WIDTH  unsigned operand; sampled with start.
- y_out  out  RW  floor root, zero-extended; held until the next completion.
- rem_out  out  WIDTH  x_in − y_out^2 or x_in − y_out^3.
- busy_o  out  1  high from the cycle after acceptance until done.
- done_o  out  1  one-cycle pulse when y_out and rem_out update.

## Operation
- Reset: y_out=0, rem_out=0, busy_o=0, done_o=0, FSM to IDLE, multiplier to idle. Reset asserted mid-operation aborts it with no done_o.
- Accept: in IDLE with start=1, latch x into the remainder register, latch mode, clear y, and set s = 2·floor((WIDTH−1)/2) for sqrt or 3·floor((WIDTH−1)/3) for cbrt.
- start while busy_o=1 is ignored. It is not queued.
- Per iteration:
  - SHIFT: y ← y<<1. In cbrt mode, issue mult(y, y+1) using the shifted y.
  - MUL_WAIT (cbrt only): wait for mult done, then latch product p.
  - TRIAL: form t = 2y+1 (sqrt) or t = 3p+1 = (p<<1)+p+1 (cbrt). If (rem>>s) ≥ t, then rem ← rem − (t<<s) and y ← y+1.
  - NEXT: if s ≥ step (2 or 3), then s ← s − step and go to SHIFT. Otherwise write y_out and rem_out, pulse done_o, drop busy_o, and return to IDLE.
- Arithmetic widths:
  - p and t are 2·RW+2 bits.
  - The compare uses the shifted-down remainder, so no shifted term exceeds WIDTH bits.
  - The subtraction never underflows.
- States: IDLE, SHIFT, MUL_WAIT, TRIAL, NEXT.

## Timing
- Iterations: N = s0/step + 1. WIDTH=8 gives N=4 (sqrt) and N=3 (cbrt).
- Cycles per iteration: 3 for sqrt; 3+RW for cbrt, because the multiplier takes RW cycles from start to done.
- Latency: done_o is high on cycle N·L + 1 after the accepting edge.
  - WIDTH=8 sqrt: 13 cycles.
  - WIDTH=8 cbrt: 22 cycles.
- busy_o falls on the same edge as done_o rises. A new start is accepted on the following cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `root_pkg`:
  - mode constants MODE_SQRT=0 and MODE_CBRT=1;
  - FSM state encoding;
  - constant functions for s0(WIDTH, mode) and the iteration count.
- Sub-module `shift_add_mult` (parameter W):
  - radix-2 shift-add multiplier with start/busy/done;
  - 2W-bit product;
  - latency W cycles;
  - reset as above.
- There is one multiplier instance only. Sqrt mode never starts it.

## Test plan
- WIDTH=8, mode=1, x_in=216 → y_out=6, rem_out=0, done_o 22 cycles after start; then x_in=255 → y_out=6, rem_out=39.
- WIDTH=8, mode=0, x_in=255 → y_out=15, rem_out=30, done_o at cycle 13; x_in=0 in both modes → y_out=0, rem_out=0.
- WIDTH=8, sweep x_in 0..255 in both modes against a reference model; check y_out^k ≤ x_in < (y_out+1)^k and rem_out exact.
- WIDTH=16: cbrt(65535) → 40 rem 1535; sqrt(65535) → 255 rem 510.
- Second start pulsed mid-operation with different x_in/mode → ignored; exactly one done_o with the first request's result; start on the cycle after done_o is accepted.
- rst asserted during MUL_WAIT → busy_o and done_o low immediately, outputs 0; the next request completes correctly with nominal latency.
